// File: rtl/mmio_io_port_pkg.sv
// mmio_io_port_pkg: register offsets and STATUS/CTRL bit positions for the MMIO I/O port.
package mmio_io_port_pkg;
  typedef enum logic [1:0] {
    OFF_TXDATA = 2'd0,
    OFF_STATUS = 2'd1,
    OFF_RXDATA = 2'd2,
    OFF_CTRL   = 2'd3
  } reg_off_e;
  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_OVF      = 3;
  localparam int CTRL_RX_ACK  = 0;
  localparam int CTRL_CLR_OVF = 1;
endpackage

// File: rtl/mmio_io_port_fifo.sv
// byte_fifo: circular byte FIFO with occupancy count; storage is not reset.
module byte_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_push,
  input  logic [7:0]    i_data,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  output logic [7:0]    o_head
);
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic          w_push, w_pop;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clock)
    if (w_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/mmio_io_port.sv
// mmio_io_port: 4-byte MMIO window on the shared bus with a TX byte FIFO and an RX holding register.
module mmio_io_port
  import mmio_io_port_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hF0,
  parameter int         DEPTH     = 4,
  localparam int        AW        = $clog2(DEPTH)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic       we,
  inout  wire  [7:0] data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);
  logic       w_hit, w_wr, w_push_req, w_ctrl_wr, w_rx_ack, w_clr_ovf, w_rx_cap;
  logic       w_full, w_empty;
  logic [AW:0] w_count;
  logic [7:0] w_status, w_rdata;
  reg_off_e   w_off;
  logic       r_ovf, r_rx_full;
  logic [7:0] r_hold;
  assign w_hit      = (address[7:2] == BASE_ADDR[7:2]);
  assign w_off      = reg_off_e'(address[1:0]);
  assign w_wr       = w_hit && we;
  assign w_push_req = w_wr && (w_off == OFF_TXDATA);
  assign w_ctrl_wr  = w_wr && (w_off == OFF_CTRL);
  assign w_rx_ack   = w_ctrl_wr && data[CTRL_RX_ACK];
  assign w_clr_ovf  = w_ctrl_wr && data[CTRL_CLR_OVF];
  assign rx_ready   = !r_rx_full && !reset;
  assign w_rx_cap   = rx_valid && rx_ready;
  assign tx_valid   = !w_empty;
  byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push_req),
    .i_data  (data),
    .i_pop   (tx_ready),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (tx_data)
  );
  // Overflow is judged against the pre-pop fullness, so a set beats a same-cycle clear.
  always_ff @(posedge clock or posedge reset)
    if (reset) r_ovf <= 1'b0;
    else if (w_push_req && w_full) r_ovf <= 1'b1;
    else if (w_clr_ovf) r_ovf <= 1'b0;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_rx_full <= 1'b0;
      r_hold    <= '0;
    end else if (w_rx_cap) begin
      r_rx_full <= 1'b1;
      r_hold    <= rx_data;
    end else if (w_rx_ack) r_rx_full <= 1'b0;
  always_comb begin
    w_status              = '0;
    w_status[ST_TX_FULL]  = w_full;
    w_status[ST_TX_EMPTY] = w_empty;
    w_status[ST_RX_FULL]  = r_rx_full;
    w_status[ST_OVF]      = r_ovf;
  end
  assign w_rdata = (w_off == OFF_TXDATA) ? 8'(w_count) :
                   (w_off == OFF_STATUS) ? w_status :
                   (w_off == OFF_RXDATA) ? r_hold : 8'h00;
  assign data = (w_hit && !we) ? w_rdata : 8'bz;
endmodule
